// File: rtl/data_sender_arq_if.sv
// Signal bundle between the ARQ controller, the game logic, the shared serializer and the ACK receiver.
// The master side is the controller; the slave side is its environment.
interface data_sender_arq_if #(
  parameter int NUM_CH = 4,
  parameter int SEQ_W  = 2
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              game_active;
  logic [NUM_CH-1:0] ch_en;
  logic              ack_valid;
  logic [CH_W-1:0]   ack_ch;
  logic [SEQ_W-1:0]  ack_seq;
  logic              send_done;
  logic              send_start;
  logic [CH_W-1:0]   send_ch;
  logic [SEQ_W-1:0]  send_seq;
  logic              send_abort;
  logic              busy;
  logic [NUM_CH-1:0] link_fail;

  modport master (
    input  game_active, ch_en, ack_valid, ack_ch, ack_seq, send_done,
    output send_start, send_ch, send_seq, send_abort, busy, link_fail
  );

  modport slave (
    output game_active, ch_en, ack_valid, ack_ch, ack_seq, send_done,
    input  send_start, send_ch, send_seq, send_abort, busy, link_fail
  );
endinterface

// File: rtl/data_sender_arq.sv
// Stop-and-wait ARQ controller: NUM_CH channels share one serializer under a round-robin grant,
// each with its own sequence number, retry budget, timeout timer and sticky link-fail flag.
module data_sender_arq #(
  parameter int NUM_CH         = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAX_RETRIES    = 3,
  parameter int SEQ_W          = 2
) (
  input  logic              clk,
  input  logic              rst,
  data_sender_arq_if.master bus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW   = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0]   RETRY_MAX  = RW'(MAX_RETRIES);
  localparam logic [CH_W-1:0] CH_LAST    = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {S_IDLE, S_PEND, S_SEND, S_WAIT, S_FAIL} ch_state_e;

  ch_state_e         state_q   [NUM_CH];
  ch_state_e         state_d   [NUM_CH];
  logic [SEQ_W-1:0]  seq_q     [NUM_CH];
  logic [SEQ_W-1:0]  seq_d     [NUM_CH];
  logic [RW-1:0]     retries_q [NUM_CH];
  logic [RW-1:0]     retries_d [NUM_CH];
  logic [TW-1:0]     timer_q   [NUM_CH];
  logic [TW-1:0]     timer_d   [NUM_CH];
  logic [NUM_CH-1:0] link_fail_q, link_fail_d;
  logic [CH_W-1:0]   last_grant_q, last_grant_d;
  logic              send_start_q, send_start_d;
  logic [CH_W-1:0]   send_ch_q, send_ch_d;
  logic [SEQ_W-1:0]  send_seq_q, send_seq_d;
  logic              send_abort_q, send_abort_d;
  logic              busy_q, busy_d;

  logic [NUM_CH-1:0] en;
  logic              any_send;
  logic              grant_vld;
  logic [CH_W-1:0]   grant_ch;
  logic [CH_W-1:0]   cand;

  always_comb begin
    en = {NUM_CH{bus.game_active}} & bus.ch_en;
  end

  // Grant only when the serializer was idle before this edge; search starts after last_grant.
  always_comb begin
    any_send  = 1'b0;
    grant_vld = 1'b0;
    grant_ch  = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (state_q[i] == S_SEND) any_send = 1'b1;
    end
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((32'(last_grant_q) + k) % NUM_CH);
      if (!any_send && !grant_vld && state_q[cand] == S_PEND && en[cand]) begin
        grant_vld = 1'b1;
        grant_ch  = cand;
      end
    end
  end

  always_comb begin
    send_start_d = grant_vld;
    send_ch_d    = grant_vld ? grant_ch : send_ch_q;
    send_seq_d   = grant_vld ? seq_q[grant_ch] : send_seq_q;
    last_grant_d = grant_vld ? grant_ch : last_grant_q;
    send_abort_d = 1'b0;
    busy_d       = 1'b0;
    link_fail_d  = link_fail_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      state_d[i]   = state_q[i];
      seq_d[i]     = seq_q[i];
      retries_d[i] = retries_q[i];
      timer_d[i]   = timer_q[i];
      if (!en[i]) begin
        // Disable outranks everything, including a send_done in the same cycle.
        if (state_q[i] == S_SEND) send_abort_d = 1'b1;
        state_d[i]     = S_IDLE;
        seq_d[i]       = '0;
        retries_d[i]   = '0;
        timer_d[i]     = '0;
        link_fail_d[i] = 1'b0;
      end else begin
        case (state_q[i])
          S_IDLE: state_d[i] = S_PEND;
          S_PEND: if (grant_vld && grant_ch == CH_W'(i)) state_d[i] = S_SEND;
          S_SEND: begin
            if (bus.send_done) begin
              state_d[i] = S_WAIT;
              timer_d[i] = '0;
            end
          end
          S_WAIT: begin
            if (bus.ack_valid && bus.ack_ch == CH_W'(i) && bus.ack_seq == seq_q[i]) begin
              state_d[i]   = S_PEND;
              seq_d[i]     = seq_q[i] + SEQ_W'(1);
              retries_d[i] = '0;
            end else if (timer_q[i] == TIMER_LAST) begin
              if (retries_q[i] == RETRY_MAX) begin
                state_d[i]     = S_FAIL;
                link_fail_d[i] = 1'b1;
              end else begin
                state_d[i]   = S_PEND;
                retries_d[i] = retries_q[i] + RW'(1);
              end
            end else begin
              timer_d[i] = timer_q[i] + TW'(1);
            end
          end
          S_FAIL:  state_d[i] = S_FAIL;
          default: state_d[i] = S_IDLE;
        endcase
      end
      if (state_d[i] == S_SEND) busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i]   <= S_IDLE;
        seq_q[i]     <= '0;
        retries_q[i] <= '0;
        timer_q[i]   <= '0;
      end
      link_fail_q  <= '0;
      last_grant_q <= CH_LAST;
      send_start_q <= 1'b0;
      send_ch_q    <= '0;
      send_seq_q   <= '0;
      send_abort_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      seq_q        <= seq_d;
      retries_q    <= retries_d;
      timer_q      <= timer_d;
      link_fail_q  <= link_fail_d;
      last_grant_q <= last_grant_d;
      send_start_q <= send_start_d;
      send_ch_q    <= send_ch_d;
      send_seq_q   <= send_seq_d;
      send_abort_q <= send_abort_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.send_start = send_start_q;
  assign bus.send_ch    = send_ch_q;
  assign bus.send_seq   = send_seq_q;
  assign bus.send_abort = send_abort_q;
  assign bus.busy       = busy_q;
  assign bus.link_fail  = link_fail_q;
endmodule

// File: tb/tb_data_sender_arq.sv
// Directed bench for data_sender_arq: expected (channel, seq) of each frame is queued ahead of
// the stimulus and checked when send_start appears.
module tb_data_sender_arq;
    localparam int NUM_CH         = 2;
    localparam int TIMEOUT_CYCLES = 8;
    localparam int MAX_RETRIES    = 2;
    localparam int SEQ_W          = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_sender_arq_if #(.NUM_CH(NUM_CH), .SEQ_W(SEQ_W)) bus ();

    data_sender_arq #(
        .NUM_CH(NUM_CH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .MAX_RETRIES(MAX_RETRIES),
        .SEQ_W(SEQ_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int ch;
        int seq;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;
    int n_starts = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input int ch, input int seq);
        exp_t e;
        e.ch  = ch;
        e.seq = seq;
        sb.push_back(e);
    endtask

    // One clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (bus.send_start === 1'b1) begin
            n_starts++;
            chk("start_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("send_ch", 32'(bus.send_ch), e.ch);
                chk("send_seq", 32'(bus.send_seq), e.seq);
            end
            chk("busy_with_start", 32'(bus.busy), 32'd1);
        end
    endtask

    task automatic wait_sb(input int remaining, input int max, output int n);
        n = 0;
        while (sb.size() > remaining && n < max) begin
            tick();
            n++;
        end
        chk("start_arrived", 32'(sb.size() <= remaining), 32'd1);
    endtask

    task automatic pulse_done();
        bus.send_done = 1'b1;
        tick();
        bus.send_done = 1'b0;
    endtask

    task automatic pulse_ack(input int ch, input int seq);
        bus.ack_valid = 1'b1;
        bus.ack_ch    = 1'(ch);
        bus.ack_seq   = 2'(seq);
        tick();
        bus.ack_valid = 1'b0;
    endtask

    task automatic reset_checks();
        chk("rst_send_start", 32'(bus.send_start), 32'd0);
        chk("rst_send_ch", 32'(bus.send_ch), 32'd0);
        chk("rst_send_seq", 32'(bus.send_seq), 32'd0);
        chk("rst_send_abort", 32'(bus.send_abort), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_link_fail", 32'(bus.link_fail), 32'd0);
    endtask

    initial begin
        int n;
        int s0;
        rst = 1'b1;
        bus.game_active = 1'b0;
        bus.ch_en       = '0;
        bus.ack_valid   = 1'b0;
        bus.ack_ch      = '0;
        bus.ack_seq     = '0;
        bus.send_done   = 1'b0;
        repeat (3) tick();
        reset_checks();
        rst = 1'b0;

        // Basic: ACKed frames, sequence wraps after four
        bus.game_active = 1'b1;
        bus.ch_en       = 2'b01;
        push(0, 0);
        wait_sb(0, 20, n);
        chk("enable_to_start", n, 2);
        tick();
        chk("start_one_cycle", 32'(bus.send_start), 32'd0);
        chk("busy_in_send", 32'(bus.busy), 32'd1);
        repeat (3) tick();
        pulse_done();
        chk("busy_in_wait", 32'(bus.busy), 32'd0);
        repeat (2) tick();
        pulse_ack(0, 0);
        for (int f = 1; f <= 4; f++) begin
            push(0, f % 4);
            wait_sb(0, 20, n);
            chk("ack_to_start", n, 1);
            repeat (4) tick();
            pulse_done();
            if (f < 4) begin
                repeat (2) tick();
                pulse_ack(0, f % 4);
            end
        end
        bus.ch_en = 2'b00;
        tick();
        chk("no_abort_from_wait", 32'(bus.send_abort), 32'd0);

        // Timeout and failure
        bus.ch_en = 2'b01;
        repeat (3) push(0, 0);
        wait_sb(2, 20, n);
        chk("fail_first_start", n, 2);
        for (int r = 0; r < 2; r++) begin
            tick();
            pulse_done();
            wait_sb(1 - r, 30, n);
            chk("retry_spacing", n, 9);
        end
        tick();
        pulse_done();
        repeat (7) tick();
        chk("link_fail_before_timeout", 32'(bus.link_fail), 32'd0);
        tick();
        chk("link_fail_set", 32'(bus.link_fail), 32'd1);
        s0 = n_starts;
        repeat (20) tick();
        chk("no_start_in_fail", n_starts, s0);
        bus.ch_en = 2'b00;
        tick();
        chk("link_fail_cleared", 32'(bus.link_fail), 32'd0);

        // Stale ACK ignored, then ACK coinciding with timeout wins
        bus.ch_en = 2'b01;
        push(0, 0);
        wait_sb(0, 20, n);
        tick();
        pulse_done();
        repeat (2) tick();
        pulse_ack(0, 3);
        push(0, 0);
        wait_sb(0, 20, n);
        chk("stale_ack_retransmit", n, 6);
        tick();
        pulse_done();
        repeat (7) tick();
        pulse_ack(0, 0);
        push(0, 1);
        wait_sb(0, 20, n);
        chk("ack_beats_timeout", n, 1);
        push(0, 1);
        push(0, 1);
        for (int r = 0; r < 2; r++) begin
            tick();
            pulse_done();
            wait_sb(1 - r, 30, n);
        end
        tick();
        pulse_done();
        repeat (8) tick();
        chk("fail_after_full_retries", 32'(bus.link_fail), 32'd1);
        bus.ch_en = 2'b00;
        tick();

        // Abort during SEND with a coincident send_done
        bus.ch_en = 2'b01;
        push(0, 0);
        wait_sb(0, 20, n);
        tick();
        bus.game_active = 1'b0;
        bus.send_done   = 1'b1;
        tick();
        bus.send_done   = 1'b0;
        bus.game_active = 1'b1;
        chk("abort_pulse", 32'(bus.send_abort), 32'd1);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        push(0, 0);
        tick();
        chk("abort_one_cycle", 32'(bus.send_abort), 32'd0);
        wait_sb(0, 20, n);
        chk("restart_after_abort", n, 1);

        // Reset while in WAIT with seq=2
        tick();
        pulse_done();
        pulse_ack(0, 0);
        push(0, 1);
        wait_sb(0, 20, n);
        tick();
        pulse_done();
        pulse_ack(0, 1);
        push(0, 2);
        wait_sb(0, 20, n);
        tick();
        pulse_done();
        repeat (2) tick();
        rst = 1'b1;
        bus.ch_en = 2'b11;
        tick();
        reset_checks();
        tick();
        rst = 1'b0;

        // Round-robin with prompt ACKs
        push(0, 0);
        push(1, 0);
        push(0, 1);
        push(1, 1);
        push(0, 2);
        wait_sb(4, 20, n);
        chk("reset_first_ch0", n, 2);
        for (int k = 0; k < 4; k++) begin
            wait_sb(4 - k, 20, n);
            tick();
            pulse_done();
            pulse_ack(k % 2, k / 2);
        end
        wait_sb(0, 5, n);
        bus.game_active = 1'b0;
        tick();
        chk("rr_abort", 32'(bus.send_abort), 32'd1);
        tick();
        chk("rr_idle_busy", 32'(bus.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
